ring_output_arbiter: RTL and testbench

- Per-output-port arbiter and output buffer controller for the gold ring router. One instance per output channel (CW, CCW, PE).
- Shares one output link between two input requesters, e.g. PE input plus ring input for a ring output, or CW plus CCW input for the PE output.
- Uses the router's even/odd polarity scheme: during polarity p it fills the VC-p output buffer and drains the VC-(~p) buffer onto the link.

---
 rtl/ring_output_arbiter.sv | 104 ++++++++++
 tb/tb_ring_output_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_output_arbiter.sv
// ring_output_arbiter: per-output-port arbiter and two-VC output buffer for the
// gold ring router. During polarity p the VC-p buffer is filled from one of two
// requesters (round-robin per VC) while the VC-(~p) buffer drains onto the link.
// Optional feature macro: HOPCNT_DEC_EN (saturating hop-count decrement on fill).
module ring_output_arbiter #(
  parameter int DW      = 64,
  parameter int HOP_MSB = 55,
  parameter int HOP_LSB = 48
) (
  input  logic          clk,
  input  logic          reset,      // asynchronous, active-low
  input  logic          polarity,   // 0 = EVEN, 1 = ODD
  input  logic [1:0]    req0_vld,
  input  logic [DW-1:0] req0_data,
  output logic          gnt0,
  input  logic [1:0]    req1_vld,
  input  logic [DW-1:0] req1_data,
  output logic          gnt1,
  output logic          out_so,
  input  logic          out_ro,
  output logic [DW-1:0] out_do,
  output logic [1:0]    obuf_full
);

  localparam int HW = HOP_MSB - HOP_LSB + 1;

  logic [1:0]         full_q, full_d;
  logic [1:0]         rr_q, rr_d;
  logic [1:0][DW-1:0] obuf_q, obuf_d;

  logic          fill_vc;    // VC being filled this cycle
  logic          drain_vc;   // VC being drained this cycle
  logic          elig0, elig1;
  logic          gnt0_c, gnt1_c;
  logic [DW-1:0] wr_raw, wr_data;
  logic [HW-1:0] hop_in, hop_out;

  assign fill_vc  = polarity;
  assign drain_vc = ~polarity;

  // Arbitration for the fill VC and construction of the token to be stored.
  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    elig0   = req0_vld[fill_vc] & ~full_q[fill_vc];
    elig1   = req1_vld[fill_vc] & ~full_q[fill_vc];
    // rr bit 0 favours requester 0, bit 1 favours requester 1
    gnt0_c  = reset & elig0 & (~elig1 | ~rr_q[fill_vc]);
    gnt1_c  = reset & elig1 & (~elig0 |  rr_q[fill_vc]);
    wr_raw  = gnt1_c ? req1_data : req0_data;
    hop_in  = wr_raw[HOP_MSB:HOP_LSB];
`ifdef HOPCNT_DEC_EN
    // saturating decrement: a zero hop count stays zero
    hop_out = (hop_in != '0) ? hop_in - 1'b1 : hop_in;
`else
    hop_out = hop_in;
`endif
    wr_data = wr_raw;
    wr_data[HOP_MSB:HOP_LSB] = hop_out;
  end

  // Link side: drain VC sends whenever it holds a token and downstream is ready.
  always_comb begin
    out_so = full_q[drain_vc] & out_ro;
    out_do = out_so ? obuf_q[drain_vc] : '0;
  end

  assign gnt0      = gnt0_c;
  assign gnt1      = gnt1_c;
  assign obuf_full = full_q;

  // Next-state: fill VC written on grant, drain VC released on send; the two
  // always address different VCs so they never collide.
  always_comb begin
    full_d = full_q;
    rr_d   = rr_q;
    obuf_d = obuf_q;
    if (gnt0_c | gnt1_c) begin
      full_d[fill_vc] = 1'b1;
      obuf_d[fill_vc] = wr_data;
      rr_d[fill_vc]   = gnt0_c;   // the other requester gets priority next time
    end
    if (out_so) begin
      full_d[drain_vc] = 1'b0;
    end
  end

  // State registers.
  // NOTE: the buffer data is reset along with the flags so a token discarded
  // by a mid-operation reset can never reappear on the link.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= '0;
      rr_q   <= '0;
      obuf_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      full_q <= full_d;
      rr_q   <= rr_d;
      obuf_q <= obuf_d;
    end
  end

endmodule

// File: tb/tb_ring_output_arbiter.sv
// Self-checking bench for ring_output_arbiter: a small reference model predicts
// grants and link sends; stored tokens are queued per VC at grant time and
// popped when the link is expected to carry them.
module tb_ring_output_arbiter;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          polarity;
  logic [1:0]    req0_vld, req1_vld;
  logic [DW-1:0] req0_data, req1_data;
  logic          gnt0, gnt1;
  logic          out_so;
  logic          out_ro;
  logic [DW-1:0] out_do;
  logic [1:0]    obuf_full;

  ring_output_arbiter #(.DW(DW), .HOP_MSB(55), .HOP_LSB(48)) dut (
    .clk       (clk),
    .reset     (reset),
    .polarity  (polarity),
    .req0_vld  (req0_vld),
    .req0_data (req0_data),
    .gnt0      (gnt0),
    .req1_vld  (req1_vld),
    .req1_data (req1_data),
    .gnt1      (gnt1),
    .out_so    (out_so),
    .out_ro    (out_ro),
    .out_do    (out_do),
    .obuf_full (obuf_full)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [1:0]    m_full;
  logic [1:0]    m_rr;
  logic [DW-1:0] sb_vc0[$];
  logic [DW-1:0] sb_vc1[$];
  logic          cur_p;
  logic [DW-1:0] last_do;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // token as the buffer should hold it
  function automatic logic [DW-1:0] stored(input logic [DW-1:0] t);
    logic [DW-1:0] r;
    r = t;
`ifdef HOPCNT_DEC_EN
    if (r[55:48] != 8'h00) r[55:48] = r[55:48] - 8'h01;
`endif
    return r;
  endfunction

  // One router cycle at polarity cur_p: drive, predict, sample at negedge, clock.
  task automatic step(input logic [1:0] v0, input logic [DW-1:0] d0,
                      input logic [1:0] v1, input logic [DW-1:0] d1,
                      input logic ro);
    logic          p;
    logic          e0, e1, xg0, xg1, xso;
    logic [DW-1:0] xdo;
    p         = cur_p;
    polarity  = p;
    req0_vld  = v0;
    req0_data = d0;
    req1_vld  = v1;
    req1_data = d1;
    out_ro    = ro;
    e0  = v0[p] & ~m_full[p];
    e1  = v1[p] & ~m_full[p];
    xg0 = 1'b0;
    xg1 = 1'b0;
    if (e0 && e1) begin
      if (m_rr[p]) xg1 = 1'b1; else xg0 = 1'b1;
    end else begin
      xg0 = e0;
      xg1 = e1;
    end
    xso = m_full[~p] & ro;
    xdo = '0;
    if (xso) begin
      if (p == 1'b1) begin
        if (sb_vc0.size() > 0) xdo = sb_vc0.pop_front();
      end else begin
        if (sb_vc1.size() > 0) xdo = sb_vc1.pop_front();
      end
    end
    @(negedge clk);
    check("gnt0", gnt0, xg0);
    check("gnt1", gnt1, xg1);
    check("out_so", out_so, xso);
    check("out_do", out_do, xdo);
    check("obuf_full", obuf_full, m_full);
    last_do = out_do;
    @(posedge clk);
    #1;
    if (xg0 || xg1) begin
      m_full[p] = 1'b1;
      m_rr[p]   = xg0;
      if (p == 1'b0) sb_vc0.push_back(stored(xg1 ? d1 : d0));
      else           sb_vc1.push_back(stored(xg1 ? d1 : d0));
    end
    if (xso) m_full[~p] = 1'b0;
    cur_p = ~cur_p;
  endtask

  task automatic idle(input logic ro);
    step(2'b00, '0, 2'b00, '0, ro);
  endtask

  // burn a cycle if needed so the next step runs at polarity p
  task automatic align(input logic p, input logic ro);
    if (cur_p != p) idle(ro);
  endtask

  task automatic model_reset();
    m_full = '0;
    m_rr   = '0;
    sb_vc0.delete();
    sb_vc1.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state, with requests present to show grants are suppressed
    reset     = 1'b0;
    polarity  = 1'b0;
    req0_vld  = 2'b11;
    req1_vld  = 2'b11;
    req0_data = 64'h1;
    req1_data = 64'h2;
    out_ro    = 1'b1;
    model_reset();
    cur_p     = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_gnt0", gnt0, 1'b0);
    check("rst_gnt1", gnt1, 1'b0);
    check("rst_out_so", out_so, 1'b0);
    check("rst_out_do", out_do, '0);
    check("rst_obuf_full", obuf_full, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // single token; its hop field [55:48] is zero, so both builds send it unchanged
    step(2'b01, 64'h0000_0400_0000_0001, 2'b00, '0, 1'b1);
    step(2'b00, '0, 2'b00, '0, 1'b1);
    check("single_data", last_do, 64'h0000_0400_0000_0001);
    idle(1'b1);

    // round-robin over four even cycles, odd cycles drain
    for (int i = 0; i < 4; i++) begin
      align(1'b0, 1'b1);
      step(2'b01, 64'h0000_0000_0000_0a00 + i, 2'b01, 64'h0000_0000_0000_0b00 + i, 1'b1);
      step(2'b01, '0, 2'b01, '0, 1'b1);
    end

    // backpressure on VC0
    align(1'b0, 1'b0);
    step(2'b01, 64'h0000_0000_0000_0c01, 2'b00, '0, 1'b0);
    step(2'b01, 64'h0000_0000_0000_0c02, 2'b00, '0, 1'b0);
    step(2'b01, 64'h0000_0000_0000_0c02, 2'b00, '0, 1'b0);
    check("bp_full", obuf_full, 2'b01);
    step(2'b01, 64'h0000_0000_0000_0c02, 2'b00, '0, 1'b1);  // odd: drain
    step(2'b01, 64'h0000_0000_0000_0c02, 2'b00, '0, 1'b1);  // even: regrant
    idle(1'b1);
    idle(1'b1);

    // both VCs back to back
    align(1'b0, 1'b1);
    step(2'b01, 64'h0000_0000_0000_d000, 2'b00, '0, 1'b1);
    step(2'b00, '0, 2'b10, 64'h8000_0000_0000_d001, 1'b1);
    check("vc0_send", last_do, 64'h0000_0000_0000_d000);
    step(2'b00, '0, 2'b00, '0, 1'b1);
    check("vc1_send", last_do, 64'h8000_0000_0000_d001);
    idle(1'b1);
    check("idle_zero", last_do, '0);

    // hop field: zero saturates, nonzero decrements when the feature is built in
    align(1'b0, 1'b1);
    step(2'b01, 64'h4000_0000_dead_beef, 2'b00, '0, 1'b1);
    step(2'b00, '0, 2'b10, 64'hc004_0000_0000_0007, 1'b1);
    check("hop_zero", last_do, 64'h4000_0000_dead_beef);
    step(2'b00, '0, 2'b00, '0, 1'b1);
`ifdef HOPCNT_DEC_EN
    check("hop_dec", last_do, 64'hc003_0000_0000_0007);
`else
    check("hop_keep", last_do, 64'hc004_0000_0000_0007);
`endif
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 200; i++) begin
      step(2'($urandom_range(0, 3)), {$urandom, $urandom},
           2'($urandom_range(0, 3)), {$urandom, $urandom},
           ($urandom_range(0, 3) != 0));
    end

    // mid-operation reset: fill both VCs with the link stalled, leaving rr[0] on requester 1
    align(1'b0, 1'b0);
    step(2'b01, 64'h0000_0000_0000_e000, 2'b00, '0, 1'b0);
    step(2'b10, 64'h8000_0000_0000_e001, 2'b00, '0, 1'b0);
    check("pre_rst_full", obuf_full, 2'b11);
    reset    = 1'b0;
    req0_vld = 2'b11;
    req1_vld = 2'b11;
    out_ro   = 1'b1;
    #2;
    check("mid_rst_obuf_full", obuf_full, 2'b00);
    check("mid_rst_out_so", out_so, 1'b0);
    check("mid_rst_gnt0", gnt0, 1'b0);
    check("mid_rst_gnt1", gnt1, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cur_p = 1'b0;
    step(2'b01, 64'h0000_0000_0000_f000, 2'b01, 64'h0000_0000_0000_f001, 1'b1);
    check("post_rst_first", m_rr[0], 1'b1);
    step(2'b00, '0, 2'b00, '0, 1'b1);
    check("post_rst_data", last_do, 64'h0000_0000_0000_f000);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
